// File: rtl/id_issue_launch_pkg.sv
// id_issue_launch_pkg: shared widths, dual-issue switch and serial FSM encoding for the issue stage.
package id_issue_launch_pkg;
    localparam int LINE_DATA_W   = 128;
    localparam int REG_AW        = 5;
    localparam int DOUBLE_LAUNCH = 1;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_DONE = 2'd1
    } serial_state_t;
endpackage

// File: rtl/id_issue_launch_hazard_check.sv
// issue_hazard_check: pair RAW, load-use against the EXE pair, and mem-port conflict for the two tail lines.
module issue_hazard_check
#(
    parameter int REG_AW = id_issue_launch_pkg::REG_AW
)(
    input  logic [REG_AW-1:0] line1_rj,
    input  logic [REG_AW-1:0] line1_rk,
    input  logic [REG_AW-1:0] line1_rd,
    input  logic              line1_rj_re,
    input  logic              line1_rk_re,
    input  logic              line1_rd_we,
    input  logic              line1_is_mem,
    input  logic [REG_AW-1:0] line2_rj,
    input  logic [REG_AW-1:0] line2_rk,
    input  logic              line2_rj_re,
    input  logic              line2_rk_re,
    input  logic              line2_is_mem,
    input  logic              exe1_valid,
    input  logic              exe1_load,
    input  logic [REG_AW-1:0] exe1_rd,
    input  logic              exe2_valid,
    input  logic              exe2_load,
    input  logic [REG_AW-1:0] exe2_rd,
    output logic              raw_12,
    output logic              ld_use_1,
    output logic              ld_use_2,
    output logic              struct_conflict
);
    // r0 is hardwired, so it never matches as a dependency.
    function automatic logic reads(
        input logic [REG_AW-1:0] rj,
        input logic [REG_AW-1:0] rk,
        input logic              rj_re,
        input logic              rk_re,
        input logic [REG_AW-1:0] r
    );
        return (r != '0) && ((rj_re && rj == r) || (rk_re && rk == r));
    endfunction

    logic exe1_ld, exe2_ld;

    always_comb begin
        exe1_ld         = exe1_valid && exe1_load;
        exe2_ld         = exe2_valid && exe2_load;
        raw_12          = line1_rd_we && reads(line2_rj, line2_rk, line2_rj_re, line2_rk_re, line1_rd);
        ld_use_1        = (exe1_ld && reads(line1_rj, line1_rk, line1_rj_re, line1_rk_re, exe1_rd))
                       || (exe2_ld && reads(line1_rj, line1_rk, line1_rj_re, line1_rk_re, exe2_rd));
        ld_use_2        = (exe1_ld && reads(line2_rj, line2_rk, line2_rj_re, line2_rk_re, exe1_rd))
                       || (exe2_ld && reads(line2_rj, line2_rk, line2_rj_re, line2_rk_re, exe2_rd));
        struct_conflict = line1_is_mem && line2_is_mem;
    end
endmodule

// File: rtl/id_issue_launch.sv
// id_issue_launch: decides zero/single/double launch from the IF/ID queue tail and owns the ID-to-EXE register.
module id_issue_launch
#(
    parameter int LINE_DATA_W   = id_issue_launch_pkg::LINE_DATA_W,
    parameter int REG_AW        = id_issue_launch_pkg::REG_AW,
    parameter int DOUBLE_LAUNCH = id_issue_launch_pkg::DOUBLE_LAUNCH
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   line1_valid_i,
    input  logic                   line2_valid_i,
    input  logic [LINE_DATA_W-1:0] line1_data_i,
    input  logic [LINE_DATA_W-1:0] line2_data_i,
    input  logic [REG_AW-1:0]      line1_rj_i,
    input  logic [REG_AW-1:0]      line1_rk_i,
    input  logic [REG_AW-1:0]      line1_rd_i,
    input  logic [REG_AW-1:0]      line2_rj_i,
    input  logic [REG_AW-1:0]      line2_rk_i,
    input  logic [REG_AW-1:0]      line2_rd_i,
    input  logic                   line1_rj_re_i,
    input  logic                   line1_rk_re_i,
    input  logic                   line1_rd_we_i,
    input  logic                   line2_rj_re_i,
    input  logic                   line2_rk_re_i,
    input  logic                   line2_rd_we_i,
    input  logic                   line1_is_load_i,
    input  logic                   line1_is_mem_i,
    input  logic                   line1_is_br_i,
    input  logic                   line1_is_serial_i,
    input  logic                   line2_is_load_i,
    input  logic                   line2_is_mem_i,
    input  logic                   line2_is_br_i,
    input  logic                   line2_is_serial_i,
    input  logic                   exe_allowin_i,
    input  logic                   pipe_empty_i,
    input  logic                   serial_done_i,
    output logic                   double_launch_o,
    output logic                   single_launch_o,
    output logic                   zero_launch_o,
    output logic                   exe_line1_valid_o,
    output logic                   exe_line2_valid_o,
    output logic [LINE_DATA_W-1:0] exe_line1_data_o,
    output logic [LINE_DATA_W-1:0] exe_line2_data_o
);
    import id_issue_launch_pkg::*;

    serial_state_t     state, state_nxt;
    logic              zero, single, dbl, drain_wait, force_single;
    logic              raw_12, ld_use_1, ld_use_2, struct_conflict;
    logic              exe1_load, exe2_load;
    logic [REG_AW-1:0] exe1_rd, exe2_rd;
    logic              unused_br2;

    // A branch in the second slot pairs freely; only line1 branches force a single launch.
    assign unused_br2 = line2_is_br_i;

    issue_hazard_check #(.REG_AW(REG_AW)) u_hazard (
        .line1_rj        (line1_rj_i),
        .line1_rk        (line1_rk_i),
        .line1_rd        (line1_rd_i),
        .line1_rj_re     (line1_rj_re_i),
        .line1_rk_re     (line1_rk_re_i),
        .line1_rd_we     (line1_rd_we_i),
        .line1_is_mem    (line1_is_mem_i),
        .line2_rj        (line2_rj_i),
        .line2_rk        (line2_rk_i),
        .line2_rj_re     (line2_rj_re_i),
        .line2_rk_re     (line2_rk_re_i),
        .line2_is_mem    (line2_is_mem_i),
        .exe1_valid      (exe_line1_valid_o),
        .exe1_load       (exe1_load),
        .exe1_rd         (exe1_rd),
        .exe2_valid      (exe_line2_valid_o),
        .exe2_load       (exe2_load),
        .exe2_rd         (exe2_rd),
        .raw_12          (raw_12),
        .ld_use_1        (ld_use_1),
        .ld_use_2        (ld_use_2),
        .struct_conflict (struct_conflict)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? RUN : state_nxt;

    always_comb begin
        state_nxt = flush_i ? RUN
                  : (state == RUN) ? ((single && line1_is_serial_i) ? WAIT_DONE : RUN)
                  : (serial_done_i ? RUN : state);
    end

    // A serial line waits until the whole back end, including our own EXE slot, has drained.
    always_comb begin
        drain_wait   = line1_is_serial_i && !(pipe_empty_i && !exe_line1_valid_o);
        zero         = !rst_n || flush_i || !line1_valid_i || !exe_allowin_i || (state != RUN)
                    || ld_use_1 || drain_wait;
        force_single = (DOUBLE_LAUNCH == 0) || !line2_valid_i || line1_is_serial_i || line1_is_br_i
                    || line2_is_serial_i || struct_conflict || raw_12 || ld_use_2;
        single       = !zero && force_single;
        dbl          = !zero && !force_single;
    end

    assign double_launch_o = dbl;
    assign single_launch_o = single;
    assign zero_launch_o   = zero;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            exe_line1_valid_o <= 1'b0;
            exe_line2_valid_o <= 1'b0;
            exe_line1_data_o  <= '0;
            exe_line2_data_o  <= '0;
            exe1_load         <= 1'b0;
            exe2_load         <= 1'b0;
            exe1_rd           <= '0;
            exe2_rd           <= '0;
        end else if (exe_allowin_i) begin
            exe_line1_valid_o <= line1_valid_i && !zero;
            exe_line2_valid_o <= line2_valid_i && dbl;
            if (line1_valid_i && !zero) begin
                exe_line1_data_o <= line1_data_i;
                exe1_load        <= line1_is_load_i && line1_rd_we_i;
                exe1_rd          <= line1_rd_i;
            end
            if (line2_valid_i && dbl) begin
                exe_line2_data_o <= line2_data_i;
                exe2_load        <= line2_is_load_i && line2_rd_we_i;
                exe2_rd          <= line2_rd_i;
            end
        end
    end

    always_ff @(posedge clk)
        assert ($onehot({double_launch_o, single_launch_o, zero_launch_o}));
endmodule

// File: tb/tb_id_issue_launch.sv
// tb_id_issue_launch: directed and random stimulus checked against a rule-level issue model.
module tb_id_issue_launch;
    typedef struct packed {
        logic         v;
        logic [127:0] d;
        logic [4:0]   rj, rk, rd;
        logic         rjre, rkre, rdwe, ld, mem, br, ser;
    } line_t;

    typedef struct packed {
        logic         v;
        logic [127:0] d;
        logic         ld;
        logic [4:0]   rd;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n, flush, allowin, pipe_empty, serial_done;
    line_t l1, l2;
    logic dl, sl, zl, ev1, ev2;
    logic [127:0] ed1, ed2;

    ent_t m1, m2;
    bit   mwait;
    int   cmp = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_issue_launch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush),
        .line1_valid_i     (l1.v),
        .line2_valid_i     (l2.v),
        .line1_data_i      (l1.d),
        .line2_data_i      (l2.d),
        .line1_rj_i        (l1.rj),
        .line1_rk_i        (l1.rk),
        .line1_rd_i        (l1.rd),
        .line2_rj_i        (l2.rj),
        .line2_rk_i        (l2.rk),
        .line2_rd_i        (l2.rd),
        .line1_rj_re_i     (l1.rjre),
        .line1_rk_re_i     (l1.rkre),
        .line1_rd_we_i     (l1.rdwe),
        .line2_rj_re_i     (l2.rjre),
        .line2_rk_re_i     (l2.rkre),
        .line2_rd_we_i     (l2.rdwe),
        .line1_is_load_i   (l1.ld),
        .line1_is_mem_i    (l1.mem),
        .line1_is_br_i     (l1.br),
        .line1_is_serial_i (l1.ser),
        .line2_is_load_i   (l2.ld),
        .line2_is_mem_i    (l2.mem),
        .line2_is_br_i     (l2.br),
        .line2_is_serial_i (l2.ser),
        .exe_allowin_i     (allowin),
        .pipe_empty_i      (pipe_empty),
        .serial_done_i     (serial_done),
        .double_launch_o   (dl),
        .single_launch_o   (sl),
        .zero_launch_o     (zl),
        .exe_line1_valid_o (ev1),
        .exe_line2_valid_o (ev2),
        .exe_line1_data_o  (ed1),
        .exe_line2_data_o  (ed2)
    );

    function automatic line_t alu(int rd, int rj, int rk);
        line_t l = '0;
        l.v = 1'b1;
        l.d = {$urandom, $urandom, $urandom, $urandom};
        l.rd = 5'(rd);
        l.rj = 5'(rj);
        l.rk = 5'(rk);
        l.rjre = 1'b1;
        l.rkre = 1'b1;
        l.rdwe = 1'b1;
        return l;
    endfunction

    function automatic line_t load(int rd, int rj);
        line_t l = alu(rd, rj, 0);
        l.rkre = 1'b0;
        l.ld = 1'b1;
        l.mem = 1'b1;
        return l;
    endfunction

    function automatic line_t ser();
        line_t l = alu(0, 1, 2);
        l.rdwe = 1'b0;
        l.ser = 1'b1;
        return l;
    endfunction

    function automatic line_t rnd();
        line_t l = alu($urandom % 4, $urandom % 4, $urandom % 4);
        l.v = ($urandom % 4) != 0;
        l.rjre = $urandom;
        l.rkre = $urandom;
        l.rdwe = $urandom;
        l.ld = l.rdwe && ($urandom % 3 == 0);
        l.mem = l.ld || ($urandom % 5 == 0);
        l.br = ($urandom % 8) == 0;
        l.ser = ($urandom % 8) == 0;
        return l;
    endfunction

    function automatic bit uses(line_t l, logic [4:0] r);
        return r != 0 && ((l.rjre && l.rj == r) || (l.rkre && l.rk == r));
    endfunction

    function automatic bit load_use(line_t l);
        return (m1.v && m1.ld && uses(l, m1.rd)) || (m2.v && m2.ld && uses(l, m2.rd));
    endfunction

    // 0 = zero, 1 = single, 2 = double
    function automatic int predict();
        if (!rst_n || flush || !l1.v || !allowin || mwait || load_use(l1) || (l1.ser && !(pipe_empty && !m1.v)))
            return 0;
        if (!l2.v || l1.ser || l1.br || l2.ser || (l1.mem && l2.mem) || (l1.rdwe && uses(l2, l1.rd)) || load_use(l2))
            return 1;
        return 2;
    endfunction

    function automatic logic [2:0] onehot(int k);
        return k == 2 ? 3'b100 : k == 1 ? 3'b010 : 3'b001;
    endfunction

    task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
        cmp++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, o, e);
        end
    endtask

    task automatic cyc(string tag, int plan = -1);
        int k;
        #1;
        k = predict();
        chk({tag, ":launch"}, 128'({dl, sl, zl}), 128'(onehot(k)));
        if (plan >= 0)
            chk({tag, ":plan"}, 128'({dl, sl, zl}), 128'(onehot(plan)));
        if (!rst_n || flush) begin
            m1 = '0;
            m2 = '0;
            mwait = 1'b0;
        end else begin
            if (allowin) begin
                m1.v = k != 0;
                m2.v = k == 2;
                if (k != 0) begin m1.d = l1.d; m1.ld = l1.ld; m1.rd = l1.rd; end
                if (k == 2) begin m2.d = l2.d; m2.ld = l2.ld; m2.rd = l2.rd; end
            end
            mwait = mwait ? !serial_done : (k == 1 && l1.ser);
        end
        @(posedge clk);
        #1;
        chk({tag, ":v1"}, 128'(ev1), 128'(m1.v));
        chk({tag, ":v2"}, 128'(ev2), 128'(m2.v));
        chk({tag, ":d1"}, ed1, m1.d);
        chk({tag, ":d2"}, ed2, m2.d);
    endtask

    initial begin
        line_t keep;
        m1 = '0;
        m2 = '0;
        mwait = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        allowin = 1'b1;
        pipe_empty = 1'b1;
        serial_done = 1'b0;
        l1 = alu(1, 2, 3);
        l2 = alu(4, 5, 6);
        cyc("reset0", 0);
        cyc("reset1", 0);
        rst_n = 1'b1;
        cyc("dual", 2);
        l1 = alu(5, 1, 2);
        l2 = alu(7, 5, 0);
        keep = l2;
        cyc("raw", 1);
        l1 = keep;
        l2 = alu(8, 9, 10);
        cyc("raw_next", 2);
        l1 = load(7, 1);
        l2 = '0;
        cyc("load", 1);
        l1 = alu(9, 7, 1);
        l2 = alu(10, 11, 12);
        cyc("ld_use", 0);
        cyc("ld_use_clear", 2);
        l1 = load(0, 1);
        l2 = '0;
        cyc("load_r0", 1);
        l1 = alu(3, 0, 0);
        l2 = alu(11, 12, 13);
        cyc("r0_no_stall", 2);
        l1 = ser();
        l2 = alu(14, 15, 16);
        pipe_empty = 1'b0;
        for (int i = 0; i < 3; i++) cyc("drain", 0);
        pipe_empty = 1'b1;
        cyc("serial_go", 1);
        l1 = alu(1, 2, 3);
        l2 = alu(4, 5, 6);
        cyc("wait0", 0);
        cyc("wait1", 0);
        serial_done = 1'b1;
        cyc("done_same", 0);
        serial_done = 1'b0;
        cyc("done_next", 2);
        l1 = alu(1, 2, 3);
        l2 = alu(4, 5, 6);
        cyc("pre_stall", 2);
        allowin = 1'b0;
        cyc("stall0", 0);
        cyc("stall1", 0);
        allowin = 1'b1;
        cyc("resume", 2);
        l1 = ser();
        l2 = alu(4, 5, 6);
        cyc("ser_busy", 0);
        cyc("ser_go", 1);
        l1 = alu(1, 2, 3);
        cyc("ser_wait", 0);
        flush = 1'b1;
        cyc("flush", 0);
        flush = 1'b0;
        cyc("post_flush", 2);
        l1 = alu(1, 2, 3);
        l2 = alu(4, 5, 6);
        cyc("pre_rst", 2);
        rst_n = 1'b0;
        cyc("mid_rst", 0);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom % 100) != 0;
            flush = ($urandom % 32) == 0;
            allowin = ($urandom % 5) != 0;
            pipe_empty = ($urandom % 3) != 0;
            serial_done = mwait ? ($urandom % 4 == 0) : ($urandom % 16 == 0);
            l1 = rnd();
            l2 = rnd();
            cyc("rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
